// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler: round-robin warp fetch scheduler for the Gelato SIMT frontend.
// Picks an eligible warp, reads its PC/mask from the split/PC table, and issues a fetch request.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rdy                          global enable; low freezes FSM, rr pointer and fetch handshakes
//   warp_active_i, warp_stall_i  per-warp launch and stall status
//   pct_req_*                    one-cycle PC table read request (valid, warp)
//   pct_rsp_*                    PC table response (valid, pc, active mask)
//   fetch_*                      valid/ready fetch request to the instruction fetch stage
//   fetch_done_*                 completion of a warp's outstanding fetch
//   inflight_o                   per-warp outstanding-fetch flags
module gelato_fetch_scheduler #(
    parameter int NUM_WARPS   = 8,
    parameter int WARP_W      = 3,
    parameter int PC_W        = 32,
    parameter int NUM_THREADS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic [NUM_WARPS-1:0]   warp_active_i,
    input  logic [NUM_WARPS-1:0]   warp_stall_i,
    output logic                   pct_req_valid_o,
    output logic [WARP_W-1:0]      pct_req_warp_o,
    input  logic                   pct_rsp_valid_i,
    input  logic [PC_W-1:0]        pct_rsp_pc_i,
    input  logic [NUM_THREADS-1:0] pct_rsp_mask_i,
    output logic                   fetch_valid_o,
    input  logic                   fetch_ready_i,
    output logic [WARP_W-1:0]      fetch_warp_o,
    output logic [PC_W-1:0]        fetch_pc_o,
    output logic [NUM_THREADS-1:0] fetch_mask_o,
    input  logic                   fetch_done_valid_i,
    input  logic [WARP_W-1:0]      fetch_done_warp_i,
    output logic [NUM_WARPS-1:0]   inflight_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WARP_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WARP_W-1:0]      sel_warp_q, sel_warp_d;
    logic [NUM_WARPS-1:0]   inflight_q, inflight_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [NUM_THREADS-1:0] mask_q, mask_d;
    // A response captured while rdy was low, waiting to be acted on.
    logic                   rsp_held_q, rsp_held_d;

    logic [NUM_WARPS-1:0]   elig;
    logic                   any_elig;
    logic [WARP_W-1:0]      pick;
    logic [WARP_W-1:0]      idx;
    logic                   found;
    logic                   req_fire;
    logic                   hs;
    logic                   rsp_now;
    logic                   rsp_any;
    logic [NUM_THREADS-1:0] mask_eff;

    assign elig     = warp_active_i & ~warp_stall_i & ~inflight_q;
    assign any_elig = |elig;

    // Round-robin search starting just after rr_ptr; the index wraps
    // explicitly so no arithmetic ever exceeds WARP_W bits.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = rr_ptr_q;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (idx == WARP_W'(NUM_WARPS - 1)) ? '0 : idx + WARP_W'(1);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign req_fire = (state_q == S_IDLE) && any_elig && rdy;
    assign rsp_now  = (state_q == S_WAIT) && pct_rsp_valid_i;
    assign rsp_any  = rsp_now || rsp_held_q;
    assign mask_eff = rsp_now ? pct_rsp_mask_i : mask_q;

    // Outputs are gated by rst so nothing is asserted while reset is held.
    assign pct_req_valid_o = req_fire && !rst;
    assign pct_req_warp_o  = pct_req_valid_o ? pick : '0;
    assign fetch_valid_o   = (state_q == S_ISSUE) && rdy && !rst;
    assign hs              = fetch_valid_o && fetch_ready_i;

    assign fetch_warp_o = sel_warp_q;
    assign fetch_pc_o   = pc_q;
    assign fetch_mask_o = mask_q;
    assign inflight_o   = inflight_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_warp_d = sel_warp_q;
        pc_d       = pc_q;
        mask_d     = mask_q;
        rsp_held_d = rsp_held_q;

        // Responses are captured even with rdy low so they are not lost.
        if (rsp_now) begin
            pc_d       = pct_rsp_pc_i;
            mask_d     = pct_rsp_mask_i;
            rsp_held_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    sel_warp_d = pick;
                    rr_ptr_d   = pick;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rdy && rsp_any) begin
                    rsp_held_d = 1'b0;
                    // An all-zero mask means the warp has exited: drop it.
                    state_d    = (mask_eff != '0) ? S_ISSUE : S_IDLE;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear first so a same-warp set in the same cycle wins.
        inflight_d = inflight_q;
        if (fetch_done_valid_i) begin
            inflight_d[fetch_done_warp_i] = 1'b0;
        end
        if (hs) begin
            inflight_d[sel_warp_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= WARP_W'(NUM_WARPS - 1);
            sel_warp_q <= '0;
            inflight_q <= '0;
            pc_q       <= '0;
            mask_q     <= '0;
            rsp_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_warp_q <= sel_warp_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
            mask_q     <= mask_d;
            rsp_held_q <= rsp_held_d;
        end
    end

endmodule

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
- Warp fetch scheduler for the Gelato SIMT frontend.
- Each cycle it selects an eligible warp round-robin, then requests that warp's PC and active mask from the split/PC table.
- It presents the result as a fetch request to the instruction fetch stage.
- It is the consuming end of the PC-table/fetch-scheduler interface.

Parameters:
- NUM_WARPS, 8, number of hardware warps.
- WARP_W, 3, warp id width; equals clog2(NUM_WARPS).
- PC_W, 32, program counter width.
- NUM_THREADS, 32, threads per warp; this is the active mask width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; low freezes the block.
- warp_active_i  in  NUM_WARPS  warp launched and not exited.
- warp_stall_i  in  NUM_WARPS  warp blocked by ibuffer full or barrier.
- pct_req_valid_o  out  1  PC table read request; one-cycle pulse.
- pct_req_warp_o  out  WARP_W  warp being read.
- pct_rsp_valid_i  in  1  PC table response valid.
- pct_rsp_pc_i  in  PC_W  top-of-split-table PC.
- pct_rsp_mask_i  in  NUM_THREADS  top-of-split-table active mask.
- fetch_valid_o  out  1  fetch request valid.
- fetch_ready_i  in  1  fetch stage accepts.
- fetch_warp_o  out  WARP_W  fetch warp id.
- fetch_pc_o  out  PC_W  fetch PC.
- fetch_mask_o  out  NUM_THREADS  fetch thread mask.
- fetch_done_valid_i  in  1  instruction for a warp written into ibuffer, or discarded.
- fetch_done_warp_i  in  WARP_W  warp whose fetch completed.
- inflight_o  out  NUM_WARPS  per-warp outstanding-fetch flags, for debug and scoreboard.

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over rdy:
  - state=IDLE, rr_ptr=NUM_WARPS-1, inflight=0.
  - All outputs 0, including fetch_pc_o and fetch_mask_o.
  - Reset mid-transaction abandons it; a late pct_rsp_valid_i arriving after reset while in IDLE is ignored.
- Eligibility: elig[w] = warp_active_i[w] & ~warp_stall_i[w] & ~inflight[w].
- Round-robin pick: the first w with elig set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_WARPS.
- IDLE:
  - If any elig: pct_req_valid_o=1 and pct_req_warp_o=pick for exactly one cycle (combinational from state and elig).
  - Latch sel_warp=pick, set rr_ptr=pick, go to WAIT.
  - No elig: stay in IDLE, outputs 0.
- WAIT:
  - Hold until pct_rsp_valid_i; the response arrives at least 1 cycle after the request.
  - On response: latch pc and mask.
  - Mask != 0: go to ISSUE.
  - Mask == 0 (warp fully exited): drop the response, do not set inflight, go to IDLE.
- ISSUE:
  - fetch_valid_o=1, with fetch_warp_o, fetch_pc_o, fetch_mask_o held stable until fetch_ready_i.
  - On handshake (valid & ready & rdy): set inflight[sel_warp], go to IDLE.
  - A new pick may be requested no earlier than the cycle after the handshake, so throughput is at most one fetch per 3 cycles with a 1-cycle PC table.
  - Changes to warp_stall_i or warp_active_i while in ISSUE do not revoke fetch_valid_o.
- inflight clear:
  - fetch_done_valid_i clears inflight[fetch_done_warp_i] in any state, including WAIT and ISSUE.
  - Clearing a non-inflight warp is a no-op.
  - A same-cycle set of warp A and clear of warp B are both applied.
  - Set and clear of the same warp in one cycle cannot legally occur; if it does, set wins.
- The cleared warp becomes eligible the following cycle; elig uses registered inflight.
- rdy=0:
  - FSM, rr_ptr and inflight hold.
  - pct_req_valid_o and fetch_valid_o are forced 0; fetch_ready_i is ignored.
  - pct_rsp_valid_i in WAIT is still captured, so the response is not lost, but the state transition is deferred until rdy=1.
  - fetch_done_valid_i is still applied.
- Wrap-around: rr_ptr=NUM_WARPS-1 searches from warp 0 first.
- Widths: all ids are WARP_W bits; the modulo search uses no arithmetic overflow beyond WARP_W.

Test Plan:
- Reset, then warp_active_i=8'hFF, no stalls, PC table replies 1 cycle later with pc=0x100+w·0x10 and mask=32'hFFFF_FFFF, fetch_ready_i=1, fetch_done returned 2 cycles after each issue. Required: fetch order 0,1,...,7,0, one fetch every 3 cycles, fetch_pc_o for warp 3 = 0x130.
- warp_active_i=8'b1000_0001, warp 0 stalled. Required: only warp 7 is fetched. Without a fetch_done_valid_i, warp 7 is not re-requested and inflight_o=8'h80. After fetch_done for warp 7, it is reselected next cycle.
- Response mask=0 for warp 2. Required: no fetch_valid_o, inflight_o[2]=0, and the next pick is warp 3.
- fetch_ready_i low for 5 cycles in ISSUE while warp_stall_i of the selected warp rises. Required: fetch_valid_o and fetch_pc_o are held constant, and the handshake occurs on the 6th cycle.
- rdy=0 on the cycle pct_rsp_valid_i arrives, for 3 cycles. Required: no outputs asserted. After rdy=1, fetch_valid_o issues with the captured pc and mask.
- rst=1 while in ISSUE with inflight_o=8'h0F. Required: next cycle all outputs are 0 and inflight_o=0, and the first post-reset pick is warp 0.
